// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants used by the receiver, transmitter and RX buffer.
package uart_rx_fifo_pkg;

    // Word width agreed between the UART receiver, transmitter and buffer.
    localparam int UART_DATA_BITS = 8;

    // Default RX buffer depth in entries (power of two).
    localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream from the RX buffer to the console mux.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS
);
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    // Producer side: the RX buffer.
    modport master (output m_valid, output m_data, input m_ready);

    // Consumer side: the console mux.
    modport slave (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level,
    output logic [WIDTH-1:0] rd_data,
    output logic             dropped
);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // The extra pointer bit tells a full buffer apart from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level = wr_ptr_q - rd_ptr_q;

    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dropped = push & full & ~pop_ok;

    // Head entry is read combinationally so data is presented with m_valid.
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values from the accepted push/pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Buffers bytes from the UART receiver and streams them out via valid/ready.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DATA_BIT_COUNT = UART_DATA_BITS,
    parameter  int DEPTH          = UART_RX_FIFO_DEPTH,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_ready,
    input  logic [DATA_BIT_COUNT-1:0] rx_data,
    uart_rx_fifo_if.master            m_if,
    output logic [AW:0]               level,
    output logic                      overflow,
    input  logic                      overflow_clr
);
    logic rx_ready_q;
    logic push_req;
    logic pop;
    logic overflow_q, overflow_d;
    logic fifo_empty;
    logic fifo_full;
    logic fifo_dropped;

    // The receiver holds ready high until the next start bit; push only on its rise.
    assign push_req = rx_ready & ~rx_ready_q;

    assign m_if.m_valid = ~fifo_empty;
    assign pop          = m_if.m_valid & m_if.m_ready;
    assign overflow     = overflow_q;

    sync_fifo #(
        .WIDTH (DATA_BIT_COUNT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (rx_data),
        .pop       (pop),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level),
        .rd_data   (m_if.m_data),
        .dropped   (fifo_dropped)
    );

    // Sticky overflow: a new drop beats a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (fifo_dropped) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Edge-detector and overflow registers; ready history resets high to ignore a stale byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            overflow_q <= overflow_d;
        end
    end

    // A byte can only be dropped when the buffer is full.
    assert property (@(posedge clk) disable iff (!rst_n) fifo_dropped |-> fifo_full);
endmodule
